// File: rtl/fetch_issue.sv
// Fetch/issue stage: fetches into IR, replays LM/SM once per set register bit, handles stall/redirect.
// Optional FETCH_PERF_CNT_EN adds issue_count and stall_count outputs.
module fetch_issue #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_IR   = 16'hF000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [15:0] redirect_pc,
    input  logic        modify_ir,
    output logic [15:0] IR,
    output logic [15:0] fromPipe1PC,
    output logic        issue_valid,
    output logic        lmsm_busy,
    output logic [2:0]  lmsm_beat
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] issue_count,
    output logic [15:0] stall_count
`endif
);

    typedef enum logic {StRun, StMulti} state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] fpc_q, fpc_d;
    logic        valid_q, valid_d;
    logic [2:0]  beat_q, beat_d;
    logic [7:0]  mask_next;
    logic        replay;
    logic        advance;

    assign mask_next = ir_q[7:0] & (ir_q[7:0] - 8'd1);
    // modify_ir from decode only means something when IR holds a real instruction
    assign replay    = (mask_next != 8'd0) &&
                       ((state_q == StMulti) || (modify_ir && valid_q));
    assign advance   = !redirect_en && !stall;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        fpc_d   = fpc_q;
        valid_d = valid_q;
        beat_d  = beat_q;
        if (redirect_en) begin
            pc_d    = redirect_pc;
            ir_d    = NOP_IR;
            valid_d = 1'b0;
            state_d = StRun;
            beat_d  = 3'd0;
        end else if (!stall) begin
            if (replay) begin
                ir_d    = {ir_q[15:8], mask_next};
                beat_d  = beat_q + 3'd1;
                state_d = StMulti;
            end else begin
                ir_d    = imem_data;
                fpc_d   = pc_q;
                pc_d    = pc_q + 16'd1;
                valid_d = 1'b1;
                beat_d  = 3'd0;
                state_d = StRun;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRun;
            pc_q    <= RESET_PC;
            ir_q    <= NOP_IR;
            fpc_q   <= 16'h0000;
            valid_q <= 1'b0;
            beat_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            fpc_q   <= fpc_d;
            valid_q <= valid_d;
            beat_q  <= beat_d;
        end
    end

    assign imem_addr   = pc_q;
    assign IR          = ir_q;
    assign fromPipe1PC = fpc_q;
    assign issue_valid = valid_q;
    assign lmsm_busy   = (state_q == StMulti);
    assign lmsm_beat   = beat_q;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] issue_cnt_q, issue_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Every non-redirect, non-stall cycle loads IR with a valid instruction or beat
    always_comb begin
        issue_cnt_d = issue_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (advance) begin
            issue_cnt_d = issue_cnt_q + 16'd1;
        end
        if (stall && !redirect_en) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_cnt_q <= 16'h0000;
            stall_cnt_q <= 16'h0000;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign issue_count = issue_cnt_q;
    assign stall_count = stall_cnt_q;
`else
    logic unused_advance;
    assign unused_advance = advance;
`endif

endmodule

// File: doc/fetch_issue.md
Name: fetch_issue

Overview:
- Instruction fetch and issue stage that feeds IR and fromPipe1PC into decode.
- Closes the loop on decode's modify_ir output: for LM/SM it re-issues the same instruction once per set register bit, clearing the lowest set bit of IR[7:0] each beat and holding the PC until the list is exhausted.
- Also handles pipeline stall and PC redirect from the branch/R7 write-back path.

Parameters:
- RESET_PC, 16'h0000: PC loaded on reset.
- NOP_IR, 16'hF000: bubble instruction. Opcode 1111 decodes to the default no-op.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  16  instruction memory address; combinational, equal to pc.
- imem_data  in  16  instruction word at imem_addr, valid in the same cycle.
- stall  in  1  hazard stall; hold all state.
- redirect_en  in  1  load redirect_pc; squash the issued instruction.
- redirect_pc  in  16  new PC (PC_Imm, ALU result, or R7 value).
- modify_ir  in  1  from decode; the current IR is an LM/SM beat.
- IR  out  16  registered instruction to decode.
- fromPipe1PC  out  16  registered address of the instruction in IR.
- issue_valid  out  1  IR holds a real instruction (not a bubble).
- lmsm_busy  out  1  state is MULTI.
- lmsm_beat  out  3  zero-based beat index of the current LM/SM issue.

Behaviour:
- Reset (sync, priority over everything):
  - pc = RESET_PC
  - IR = NOP_IR
  - fromPipe1PC = 0
  - issue_valid = 0
  - state = RUN
  - lmsm_beat = 0
- Registers: pc holds the next fetch address. All outputs except imem_addr are registered.
- Event priority per cycle: reset > redirect_en > stall > normal.
- Redirect:
  - pc <= redirect_pc, IR <= NOP_IR, issue_valid <= 0, state <= RUN, lmsm_beat <= 0.
  - Any LM/SM in progress is abandoned.
  - Redirect wins over a simultaneous stall.
  - Next cycle fetches from redirect_pc.
- Stall: every register holds, including pc, IR, state and lmsm_beat. imem_addr stays stable.
- mask_next = IR[7:0] & (IR[7:0] - 1), i.e. the lowest set bit cleared, in 8-bit arithmetic.
- State RUN, normal cycle:
  - If modify_ir=1 and mask_next != 0: IR <= {IR[15:8], mask_next}, pc and fromPipe1PC hold, lmsm_beat <= lmsm_beat+1, state <= MULTI.
  - Otherwise (plain fetch): IR <= imem_data, fromPipe1PC <= pc, pc <= pc+1 (16-bit wrap, 16'hFFFF -> 0), issue_valid <= 1, lmsm_beat <= 0.
- State MULTI, normal cycle:
  - If mask_next != 0: IR <= {IR[15:8], mask_next}, lmsm_beat <= lmsm_beat+1.
  - If mask_next == 0 (final beat is in decode now): plain fetch as in RUN, state <= RUN. No bubble between the last beat and the next instruction.
- LM/SM with IR[7:0] = 0 or exactly one bit set: single issue, no MULTI entry.
- Maximum of 8 beats. lmsm_beat never exceeds 7.
- lmsm_busy = (state == MULTI).
- modify_ir is only honoured while issue_valid = 1. When issue_valid = 0 it is treated as 0.
- Latency: an instruction at address A reaches IR one cycle after imem_addr = A with no stall.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds two outputs:
  - issue_count (out, 16): increments on every cycle where IR loads with issue_valid <= 1, counting each LM/SM beat.
  - stall_count (out, 16): increments on every stall=1 cycle that has no redirect.
- Both counters reset to 0 and wrap at 16'hFFFF.
- When undefined, these ports and the counter logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset then run, memory[0..2] = 1000h, 2000h, 3000h:
  - IR follows 1000h, 2000h, 3000h.
  - fromPipe1PC follows 0, 1, 2.
  - issue_valid rises on the first cycle after reset.
- LM 6xA5h (bits 0, 2, 5, 7) at address 4, with modify_ir driven while opcode is 0110:
  - IR low byte sequence is A5h, A4h, A0h, 80h.
  - lmsm_beat goes 0, 1, 2, 3.
  - pc holds at 5.
  - The next cycle issues memory[5] with no bubble.
- Stall for 3 cycles mid-SM (IR low byte 0Ch): IR, pc and lmsm_beat are frozen, then resume at 08h.
- Redirect to 0040h during LM beat 2 with stall=1 asserted in the same cycle:
  - Next IR = F000h, issue_valid = 0, lmsm_busy = 0.
  - The following IR = memory[0040h].
- pc = FFFFh fetch: fromPipe1PC = FFFFh, next fetch address is 0000h.
- With FETCH_PERF_CNT_EN defined, run 4 plain instructions, 1 stall and one 2-beat SM: issue_count = 6, stall_count = 1.
